// File: rtl/fifo_top.sv
// Single-clock FIFO with wrap-bit pointers, registered occupancy/threshold flags
// and sticky overflow/underflow error flags.
module fifo_top #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int DEPTH           = 1 << ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t FULL_CNT = ptr_t'(DEPTH);
    localparam ptr_t AF_TH    = ptr_t'(ALMOST_FULL_TH);
    localparam ptr_t AE_TH    = ptr_t'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr, rd_ptr;
    ptr_t wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic rd_acc, wr_acc;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    always_comb begin
        rd_acc     = i_rd_en && !o_empty;
        wr_acc     = i_wr_en && (!o_full || rd_acc);
        wr_ptr_nxt = wr_ptr + ptr_t'(wr_acc);
        rd_ptr_nxt = rd_ptr + ptr_t'(rd_acc);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Flags are derived from the post-edge pointers so they are registered, not combinational.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_count        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_almost_empty <= 1'b1;
            o_almost_full  <= 1'b0;
            o_rdata        <= '0;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            o_count        <= count_nxt;
            o_empty        <= (count_nxt == '0);
            o_full         <= (count_nxt == FULL_CNT);
            o_almost_empty <= (count_nxt <= AE_TH);
            o_almost_full  <= (count_nxt >= AF_TH);
            if (rd_acc) begin
                o_rdata <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            if (i_wr_en && !wr_acc) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_en && !rd_acc) begin
                o_underflow <= 1'b1;
            end
        end
    end

    // Storage is left unreset; only pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wdata;
        end
    end

endmodule

// File: tb/tb_fifo_top.sv
// Directed vector table plus a queue-model wrap sequence and a mid-operation reset check.
module tb_fifo_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rdata;
    logic       full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_top dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wdata        (wdata),
        .i_rd_en        (rd_en),
        .o_rdata        (rdata),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (count),
        .o_overflow     (ovf),
        .o_underflow    (udf)
    );

    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [4:0] count;
        logic       empty, full, af, ae, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    // rdata[7:0] count[4:0] empty full af ae ovf udf
    function automatic logic [18:0] outs();
        return {rdata, count, empty, full, afull, aempty, ovf, udf};
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rdata=%h count=%0d e/f/af/ae/ovf/udf=%b, want rdata=%h count=%0d e/f/af/ae/ovf/udf=%b",
                     name, act[18:11], act[10:6], act[5:0], exp[18:11], exp[10:6], exp[5:0]);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst = r; wr_en = w; rd_en = rd; wdata = d;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [7:0] d,
                                input logic [7:0] q, input int c, input logic o, input logic u);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.wdata = d;
        v.rdata = q; v.count = 5'(c);
        v.empty = (c == 0); v.full = (c == 16);
        v.af = (c >= 14); v.ae = (c <= 2);
        v.ovf = o; v.udf = u;
        return v;
    endfunction

    initial begin
        logic [7:0] q[$];
        logic [7:0] m_rdata;
        logic       m_ovf, m_udf, w, r, racc, wacc;
        logic [7:0] d;

        // Reset, idle, fill 0x00..0x0F
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 1, 0, 8'(i), 8'h00, i + 1, 0, 0));
        // Overflow write of 0xAA while full: dropped
        vecs.push_back(mk(0, 1, 0, 8'hAA, 8'h00, 16, 1, 0));
        // Full read+write of 0x55: oldest out, 0x55 takes the freed slot
        vecs.push_back(mk(0, 1, 1, 8'h55, 8'h00, 16, 1, 0));
        // Drain: 0x01..0x0F then 0x55
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(0, 0, 1, 8'h00, (k < 15) ? 8'(k + 1) : 8'h55, 15 - k, 1, 0));
        // Underflow: rdata holds
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h55, 0, 1, 1));
        // Empty read+write: read rejected, write accepted
        vecs.push_back(mk(0, 1, 1, 8'h77, 8'h55, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h77, 0, 1, 1));
        // Reset clears sticky flags and rdata
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].rdata, vecs[i].count, vecs[i].empty, vecs[i].full,
                   vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf});
        end

        // Wrap: offset the pointers by 12, then random traffic against a queue model
        for (int i = 0; i < 12; i++) step(0, 1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 12; i++) step(0, 0, 1, 8'h00);
        check("offset_rdata", outs(), {8'hCB, 5'd0, 6'b100100});
        m_rdata = 8'hCB; m_ovf = 0; m_udf = 0;
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 99) < 65);
            r = ($urandom_range(0, 99) < 45);
            d = 8'($urandom);
            racc = r && (q.size() > 0);
            wacc = w && (q.size() < 16 || racc);
            if (w && !wacc) m_ovf = 1;
            if (r && !racc) m_udf = 1;
            if (racc) m_rdata = q.pop_front();
            if (wacc) q.push_back(d);
            step(0, w, r, d);
            check($sformatf("wrap%0d", i), outs(),
                  {m_rdata, 5'(q.size()), q.size() == 0, q.size() == 16,
                   q.size() >= 14, q.size() <= 2, m_ovf, m_udf});
        end

        // Mid-operation reset with 5 words held, with traffic on the same edge
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h30 + i));
        check("pre_reset_count5", outs(), {8'h00, 5'd5, 6'b000000});
        step(1, 1, 1, 8'hEE);
        check("mid_reset", outs(), {8'h00, 5'd0, 6'b100100});
        step(0, 1, 0, 8'h99);
        step(0, 0, 1, 8'h00);
        check("post_reset_first_word", outs(), {8'h99, 5'd0, 6'b100100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
